// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute sequencer with registered strobes.
// Define COND_JUMP_EN to enable the JZ/JNZ conditional jumps; otherwise opcodes 6/7 are illegal.
module fetch_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_rd,
  output logic               data_rd,
  output logic               data_wr,
  output logic [ADDR_W-1:0]  data_add,
  output logic [1:0]         alu_op,
  output logic               alu_en,
  output logic               pc_inc,
  output logic               jmp,
  output logic [ADDR_W-1:0]  jmp_add,
  output logic               halted,
  output logic               illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEMWAIT, HALT} state_t;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_JMP = 4'h5, OP_JZ = 4'h6, OP_JNZ = 4'h7, OP_HLT = 4'hF;
  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                armed_q, wb_q, wb_d;
  logic                mem_rd_q, mem_rd_d, data_rd_q, data_rd_d, data_wr_q, data_wr_d;
  logic [ADDR_W-1:0]   data_add_q, data_add_d, jmp_add_q, jmp_add_d;
  logic [1:0]          alu_op_q, alu_op_d;
  logic                alu_en_q, alu_en_d, pc_inc_q, pc_inc_d, jmp_q, jmp_d;
  logic                halted_q, halted_d, illegal_q, illegal_d;
  logic [3:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic                is_cj, take, legal, is_mem, plain;
  assign op      = ir_q[INSTR_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
`ifdef COND_JUMP_EN
  assign is_cj = op == OP_JZ || op == OP_JNZ;
`else
  assign is_cj = 1'b0;
`endif
  assign take   = op == OP_JMP || (is_cj && (op == OP_JZ ? zero : !zero));
  assign legal  = op <= OP_JMP || op == OP_HLT || is_cj;
  assign is_mem = op == OP_LOAD || op == OP_STORE;
  assign plain  = op == OP_NOP || op == OP_ADD || op == OP_SUB || !legal || (is_cj && !take);
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wb_d       = 1'b0;
    mem_rd_d   = 1'b0;
    data_rd_d  = 1'b0;
    data_wr_d  = 1'b0;
    data_add_d = '0;
    alu_op_d   = 2'b00;
    alu_en_d   = 1'b0;
    pc_inc_d   = 1'b0;
    jmp_d      = 1'b0;
    jmp_add_d  = '0;
    halted_d   = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = (run && armed_q) ? FETCH : IDLE;
        mem_rd_d = run && armed_q;
      end
      FETCH: begin
        state_d  = mem_ready ? DECODE : FETCH;
        ir_d     = mem_ready ? instr : ir_q;
        mem_rd_d = !mem_ready;
      end
      DECODE: begin
        state_d    = EXEC;
        data_rd_d  = op == OP_LOAD;
        data_wr_d  = op == OP_STORE;
        data_add_d = is_mem ? operand : '0;
        alu_en_d   = op == OP_ADD || op == OP_SUB;
        alu_op_d   = op == OP_ADD ? 2'b01 : op == OP_SUB ? 2'b10 : 2'b00;
        pc_inc_d   = plain;
        jmp_d      = take;
        jmp_add_d  = take ? operand : '0;
        illegal_d  = !legal;
      end
      EXEC: begin
        state_d    = is_mem ? MEMWAIT : op == OP_HLT ? HALT : run ? FETCH : IDLE;
        mem_rd_d   = !is_mem && op != OP_HLT && run;
        data_rd_d  = data_rd_q;
        data_wr_d  = data_wr_q;
        data_add_d = data_add_q;
        halted_d   = op == OP_HLT;
      end
      MEMWAIT: begin
        // wb_q marks the single completion cycle that carries pc_inc
        state_d    = wb_q ? (run ? FETCH : IDLE) : MEMWAIT;
        mem_rd_d   = wb_q && run;
        wb_d       = !wb_q && mem_ready;
        pc_inc_d   = !wb_q && mem_ready;
        alu_en_d   = !wb_q && mem_ready && data_rd_q;
        data_rd_d  = !wb_q && !mem_ready && data_rd_q;
        data_wr_d  = !wb_q && !mem_ready && data_wr_q;
        data_add_d = (!wb_q && !mem_ready) ? data_add_q : '0;
      end
      HALT: halted_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      armed_q    <= 1'b0;
      wb_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      data_rd_q  <= 1'b0;
      data_wr_q  <= 1'b0;
      data_add_q <= '0;
      alu_op_q   <= 2'b00;
      alu_en_q   <= 1'b0;
      pc_inc_q   <= 1'b0;
      jmp_q      <= 1'b0;
      jmp_add_q  <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      armed_q    <= 1'b1;
      wb_q       <= wb_d;
      mem_rd_q   <= mem_rd_d;
      data_rd_q  <= data_rd_d;
      data_wr_q  <= data_wr_d;
      data_add_q <= data_add_d;
      alu_op_q   <= alu_op_d;
      alu_en_q   <= alu_en_d;
      pc_inc_q   <= pc_inc_d;
      jmp_q      <= jmp_d;
      jmp_add_q  <= jmp_add_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end
  assign mem_rd   = mem_rd_q;
  assign data_rd  = data_rd_q;
  assign data_wr  = data_wr_q;
  assign data_add = data_add_q;
  assign alu_op   = alu_op_q;
  assign alu_en   = alu_en_q;
  assign pc_inc   = pc_inc_q;
  assign jmp      = jmp_q;
  assign jmp_add  = jmp_add_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed table-driven checks of fetch_sequencer plus multi-cycle sequences.
module tb_fetch_sequencer;
  logic       clk = 1'b0, rst = 1'b0, run = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic [9:0] instr = 10'h000;
  logic       mem_rd, data_rd, data_wr, alu_en, pc_inc, jmp, halted, illegal;
  logic [5:0] data_add, jmp_add;
  logic [1:0] alu_op;
  logic [21:0] outs;
  int checks = 0, errors = 0;

  fetch_sequencer #(.ADDR_W(6), .INSTR_W(10)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .mem_rd(mem_rd), .data_rd(data_rd), .data_wr(data_wr), .data_add(data_add),
    .alu_op(alu_op), .alu_en(alu_en), .pc_inc(pc_inc), .jmp(jmp), .jmp_add(jmp_add),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign outs = {mem_rd, data_rd, data_wr, data_add, alu_op, alu_en, pc_inc, jmp, jmp_add, halted, illegal};

  typedef struct {
    string      name;
    logic [9:0] ins;
    logic       z;
    logic [1:0] ao;
    logic       ae;
    logic       pi;
    logic       j;
    logic [5:0] ja;
    logic       il;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [21:0] ex(input logic mr, input logic dr, input logic dw, input logic [5:0] da,
                                     input logic [1:0] ao, input logic ae, input logic pi, input logic j,
                                     input logic [5:0] ja, input logic h, input logic il);
    return {mr, dr, dw, da, ao, ae, pi, j, ja, h, il};
  endfunction

  task automatic chk(input string name, input logic [21:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, outs, exp);
    end
  endtask

  task automatic fetch(input logic [9:0] w);
    int n = 0;
    while (!mem_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_rd) begin
      errors++;
      $display("FAIL fetch_timeout: mem_rd=%b expected 1", mem_rd);
    end
    instr = w;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b0;
    #1 chk(name, 22'h0);
    @(negedge clk);
    chk({name, "_held"}, 22'h0);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((jmp && pc_inc) || $countones({mem_rd, data_rd, data_wr}) > 1) begin
        errors++;
        $display("FAIL exclusivity: jmp=%b pc_inc=%b mem_rd=%b data_rd=%b data_wr=%b required disjoint",
                 jmp, pc_inc, mem_rd, data_rd, data_wr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"nop",     10'h000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0};
    tbl[1] = '{"add",     10'h0C0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0};
    tbl[2] = '{"sub",     10'h100, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0};
    tbl[3] = '{"jmp",     10'h151, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 6'h11, 1'b0};
    tbl[4] = '{"jmp_max", 10'h17F, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 6'h3F, 1'b0};
    tbl[5] = '{"ill_8",   10'h200, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[6] = '{"ill_c",   10'h300, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[7] = '{"ill_e",   10'h3AA, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
`ifdef COND_JUMP_EN
    tbl[8]  = '{"jz_z1",  10'h190, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 6'h10, 1'b0};
    tbl[9]  = '{"jnz_z1", 10'h1C5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0};
    tbl[10] = '{"jnz_z0", 10'h1C5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 6'h05, 1'b0};
`else
    tbl[8]  = '{"jz_z1",  10'h190, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[9]  = '{"jnz_z1", 10'h1C5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
    tbl[10] = '{"jnz_z0", 10'h1C5, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
`endif
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 22'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_edge1", 22'h0);
    @(negedge clk);
    chk("release_edge2", ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));

    foreach (tbl[k]) begin
      zero = tbl[k].z;
      fetch(tbl[k].ins);
      chk({tbl[k].name, "_decode"}, 22'h0);
      @(negedge clk);
      chk({tbl[k].name, "_exec"}, ex(1'b0, 1'b0, 1'b0, 6'h0, tbl[k].ao, tbl[k].ae, tbl[k].pi,
                                       tbl[k].j, tbl[k].ja, 1'b0, tbl[k].il));
      @(negedge clk);
      chk({tbl[k].name, "_next"}, ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    end
    zero = 1'b0;

    fetch(10'h06A);
    chk("ld_decode", 22'h0);
    @(negedge clk);
    chk("ld_exec", ex(1'b0, 1'b1, 1'b0, 6'h2A, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_wait", ex(1'b0, 1'b1, 1'b0, 6'h2A, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
      mem_ready = (i == 2);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    chk("ld_done", ex(1'b0, 1'b0, 1'b0, 6'h0, 2'b00, 1'b1, 1'b1, 1'b0, 6'h0, 1'b0, 1'b0));
    @(negedge clk);
    chk("ld_next", ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));

    fetch(10'h0BF);
    chk("st_decode", 22'h0);
    @(negedge clk);
    chk("st_exec", ex(1'b0, 1'b0, 1'b1, 6'h3F, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    mem_ready = 1'b1;
    @(negedge clk);
    chk("st_wait", ex(1'b0, 1'b0, 1'b1, 6'h3F, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    chk("st_done", ex(1'b0, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b1, 1'b0, 6'h0, 1'b0, 1'b0));
    @(negedge clk);
    chk("st_next", ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));

    fetch(10'h0C0);
    run = 1'b0;
    chk("stop_decode", 22'h0);
    @(negedge clk);
    chk("stop_exec", ex(1'b0, 1'b0, 1'b0, 6'h0, 2'b01, 1'b1, 1'b1, 1'b0, 6'h0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stop_idle", 22'h0);
    end
    run = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("fw_req", ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    @(negedge clk);
    chk("fw_hold", ex(1'b1, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    async_reset("fetch_reset");

    fetch(10'h06A);
    @(negedge clk);
    @(negedge clk);
    chk("mw_pre", ex(1'b0, 1'b1, 1'b0, 6'h2A, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 1'b0));
    async_reset("memwait_reset");

    fetch(10'h3C0);
    chk("hlt_decode", 22'h0);
    @(negedge clk);
    chk("hlt_exec", 22'h0);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      mem_ready = i[1];
      @(negedge clk);
      chk("halted", ex(1'b0, 1'b0, 1'b0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h0, 1'b1, 1'b0));
    end
    mem_ready = 1'b0;
    async_reset("halt_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
